pokey_pot_trig_scanner: RTL and testbench

- Parametrised pot-scan and trigger-latch engine for POKEY. It generalises the fixed two-pot, single-trigger wiring to NUM_POTS paddle channels and NUM_TRIGS joystick triggers.
- Pot side: on a POTGO strobe it discharges the pot capacitors, then counts scanlines and captures each channel's count when its comparator input goes high. It produces the POTn registers and the ALLPOT status.
- Trigger side: produces TRIGn, either raw or latched, selected by the GRACTL latch bit.
- Sits inside the POKEY block, between the controller interface pins and the register read mux.

---
 rtl/pokey_pkg.sv | 15 +
 rtl/pokey_trig_latch.sv | 28 ++
 rtl/pokey_pot_trig_scanner.sv | 155 +++++++++++++++
 tb/tb_pokey_pot_trig_scanner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pokey_pkg.sv
// Shared types and constants for the POKEY pot-scan and trigger logic.
// Pure declarations; no latency, no flow control.
package pokey_pkg;

    localparam int POT_W          = 8;
    localparam int MAX_COUNT_DEF  = 228;
    localparam int DUMP_TICKS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        SCAN = 2'd2
    } pot_state_t;

endpackage

// File: rtl/pokey_trig_latch.sv
// One joystick trigger: 2-FF synchroniser, sticky-low latch and raw/latched output select.
// Latency: 2 o2 cycles raw, 3 o2 cycles latched; latch_en falling returns to raw output at once.
// No backpressure: the output is a level, sampled by the register read mux at will.
module pokey_trig_latch (
    input  logic o2,
    input  logic rst_L,
    input  logic trig_in,
    input  logic latch_en,
    output logic trig_out
);

    logic [1:0] sync_q;
    logic       latch_q;

    // The latch only tracks presses while enabled; otherwise it sits at 1 so re-enabling starts clean.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            sync_q  <= 2'b11;
            latch_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], trig_in};
            latch_q <= latch_en ? (latch_q & sync_q[1]) : 1'b1;
        end
    end

    assign trig_out = latch_en ? latch_q : sync_q[1];

endmodule

// File: rtl/pokey_pot_trig_scanner.sv
// POKEY pot scan (POTGO -> dump -> count -> capture) plus NUM_TRIGS trigger latches; POKEY_POT_FAST_SCAN_EN adds fast_scan.
// Latency: captures land in pot_val/allpot the cycle after the advancing tick; inputs see 2 sync cycles first.
// No backpressure: strobes are consumed on arrival, potgo_stb always restarts the scan.
module pokey_pot_trig_scanner
    import pokey_pkg::*;
#(
    parameter int NUM_POTS   = 2,
    parameter int NUM_TRIGS  = 4,
    parameter int MAX_COUNT  = MAX_COUNT_DEF,
    parameter int DUMP_TICKS = DUMP_TICKS_DEF
) (
    input  logic                      o2,
    input  logic                      rst_L,
    input  logic                      line_tick,
    input  logic                      potgo_stb,
    input  logic [NUM_POTS-1:0]       pot_in,
    output logic [NUM_POTS-1:0]       pot_dump,
    output logic [POT_W*NUM_POTS-1:0] pot_val,
    output logic [NUM_POTS-1:0]       allpot,
    output logic                      scan_busy,
    input  logic [NUM_TRIGS-1:0]      trig_in,
    input  logic                      trig_latch_en,
`ifdef POKEY_POT_FAST_SCAN_EN
    input  logic                      fast_scan,
`endif
    output logic [NUM_TRIGS-1:0]      trig_out
);

    localparam int               DCNT_W    = (DUMP_TICKS > 1) ? $clog2(DUMP_TICKS) : 1;
    localparam logic [DCNT_W-1:0] DUMP_LAST = DCNT_W'(DUMP_TICKS - 1);
    localparam logic [POT_W-1:0]  MAX_CNT   = POT_W'(MAX_COUNT);

    pot_state_t                          state_q;
    logic [POT_W-1:0]                    counter_q;
    logic [DCNT_W-1:0]                   dump_cnt_q;
    logic [NUM_POTS-1:0]                 allpot_q;
    logic [NUM_POTS-1:0][POT_W-1:0]      pot_val_q;
    logic [NUM_POTS-1:0]                 pot_dump_q;
    logic                                scan_busy_q;
    logic [NUM_POTS-1:0]                 pot_s0_q;
    logic [NUM_POTS-1:0]                 pot_s1_q;
    logic [NUM_POTS-1:0]                 capture;
    logic                                advance;

    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            pot_s0_q <= '1;
            pot_s1_q <= '1;
        end else begin
            pot_s0_q <= pot_in;
            pot_s1_q <= pot_s0_q;
        end
    end

`ifdef POKEY_POT_FAST_SCAN_EN
    // Fast mode is latched when SCAN starts so a mid-scan SKCTL write cannot skew the count.
    logic fast_q;

    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            fast_q <= 1'b0;
        end else if (state_q == DUMP && line_tick && dump_cnt_q == DUMP_LAST && !potgo_stb) begin
            fast_q <= fast_scan;
        end
    end

    assign advance = fast_q ? 1'b1 : line_tick;
`else
    assign advance = line_tick;
`endif

    assign capture = allpot_q & pot_s1_q;

    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            dump_cnt_q  <= '0;
            allpot_q    <= '0;
            pot_val_q   <= '0;
            pot_dump_q  <= '1;
            scan_busy_q <= 1'b0;
        end else if (potgo_stb) begin
            state_q     <= DUMP;
            counter_q   <= '0;
            dump_cnt_q  <= '0;
            allpot_q    <= '1;
            pot_dump_q  <= '1;
            scan_busy_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    pot_dump_q  <= '1;
                    scan_busy_q <= 1'b0;
                end
                DUMP: begin
                    if (line_tick) begin
                        if (dump_cnt_q == DUMP_LAST) begin
                            state_q    <= SCAN;
                            counter_q  <= '0;
                            pot_dump_q <= '0;
                        end else begin
                            dump_cnt_q <= dump_cnt_q + DCNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    if (allpot_q == '0) begin
                        state_q     <= IDLE;
                        pot_dump_q  <= '1;
                        scan_busy_q <= 1'b0;
                    end else if (advance) begin
                        if (counter_q == MAX_CNT) begin
                            // Terminal count: every channel still scanning reads as full scale.
                            for (int n = 0; n < NUM_POTS; n++) begin
                                if (allpot_q[n]) pot_val_q[n] <= MAX_CNT;
                            end
                            allpot_q    <= '0;
                            state_q     <= IDLE;
                            pot_dump_q  <= '1;
                            scan_busy_q <= 1'b0;
                        end else begin
                            for (int n = 0; n < NUM_POTS; n++) begin
                                if (capture[n]) pot_val_q[n] <= counter_q;
                            end
                            allpot_q <= allpot_q & ~capture;
                            if (capture == '0) counter_q <= counter_q + POT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pot_dump_q  <= '1;
                    scan_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pot_val   = pot_val_q;
    assign allpot    = allpot_q;
    assign pot_dump  = pot_dump_q;
    assign scan_busy = scan_busy_q;

    for (genvar t = 0; t < NUM_TRIGS; t++) begin : g_trig
        pokey_trig_latch u_trig (
            .o2       (o2),
            .rst_L    (rst_L),
            .trig_in  (trig_in[t]),
            .latch_en (trig_latch_en),
            .trig_out (trig_out[t])
        );
    end

endmodule

// File: tb/tb_pokey_pot_trig_scanner.sv
// Directed plus randomised bench for pokey_pot_trig_scanner against a tick-level pot model and a cycle-level trigger model.
module tb_pokey_pot_trig_scanner;

    localparam int NP   = 2;
    localparam int NT   = 4;
    localparam int MAXC = 228;
    localparam int DT   = 2;

    logic          o2 = 1'b0;
    logic          rst_L = 1'b0;
    logic          line_tick = 1'b0;
    logic          potgo_stb = 1'b0;
    logic [NP-1:0] pot_in = '0;
    logic [NP-1:0] pot_dump;
    logic [8*NP-1:0] pot_val;
    logic [NP-1:0] allpot;
    logic          scan_busy;
    logic [NT-1:0] trig_in = '1;
    logic          trig_latch_en = 1'b0;
    logic [NT-1:0] trig_out;
`ifdef POKEY_POT_FAST_SCAN_EN
    logic          fast_scan = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_val [NP];
    int         rise    [NP];

    // Trigger reference: h0/h1 hold the input as seen one and two edges ago.
    logic [NT-1:0] h0 = '1;
    logic [NT-1:0] h1 = '1;
    logic [NT-1:0] m_latch = '1;

    always #5 o2 = ~o2;

    always @(posedge o2) begin
        if (!rst_L) begin
            h0 = '1; h1 = '1; m_latch = '1;
        end else begin
            m_latch = trig_latch_en ? (m_latch & h1) : '1;
            h1 = h0;
            h0 = trig_in;
        end
    end

    pokey_pot_trig_scanner #(
        .NUM_POTS(NP), .NUM_TRIGS(NT), .MAX_COUNT(MAXC), .DUMP_TICKS(DT)
    ) dut (
        .o2            (o2),
        .rst_L         (rst_L),
        .line_tick     (line_tick),
        .potgo_stb     (potgo_stb),
        .pot_in        (pot_in),
        .pot_dump      (pot_dump),
        .pot_val       (pot_val),
        .allpot        (allpot),
        .scan_busy     (scan_busy),
        .trig_in       (trig_in),
        .trig_latch_en (trig_latch_en),
`ifdef POKEY_POT_FAST_SCAN_EN
        .fast_scan     (fast_scan),
`endif
        .trig_out      (trig_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NP-1:0] pack_exp();
        logic [8*NP-1:0] v;
        for (int n = 0; n < NP; n++) v[8*n +: 8] = exp_val[n];
        return v;
    endfunction

    task automatic cyc();
        @(posedge o2);
        #1;
    endtask

    // Three quiet cycles then a one-cycle line_tick; returns just after the edge that sampled it.
    task automatic tick();
        repeat (3) cyc();
        line_tick = 1'b1;
        cyc();
        line_tick = 1'b0;
    endtask

    task automatic start_scan(input bit with_tick);
        pot_in = '0;
        repeat (3) cyc();
        potgo_stb = 1'b1;
        line_tick = with_tick;
        cyc();
        potgo_stb = 1'b0;
        line_tick = 1'b0;
        chk("allpot_potgo", allpot, {NP{1'b1}});
        chk("busy_potgo", scan_busy, 1);
        chk("dump_potgo", pot_dump, {NP{1'b1}});
        chk("potval_held", pot_val, pack_exp());
        for (int d = 0; d < DT; d++) begin
            tick();
            chk("dump_phase", pot_dump, (d == DT - 1) ? '0 : {NP{1'b1}});
            chk("busy_dump", scan_busy, 1);
        end
    endtask

    task automatic scan_loop(input int stop_cnt);
        int            cnt = 0;
        int            t = 0;
        bit            done = 0;
        logic [NP-1:0] ap = '1;
        logic [NP-1:0] cap;
        for (int n = 0; n < NP; n++) if (rise[n] == 0) pot_in[n] = 1'b1;
        while (!done) begin
            tick();
            if (cnt == MAXC) begin
                for (int n = 0; n < NP; n++) if (ap[n]) exp_val[n] = 8'(MAXC);
                ap = '0;
            end else begin
                cap = '0;
                for (int n = 0; n < NP; n++) begin
                    if (ap[n] && rise[n] <= t) begin
                        cap[n] = 1'b1;
                        exp_val[n] = 8'(cnt);
                    end
                end
                ap = ap & ~cap;
                if (cap == '0) cnt++;
            end
            chk("allpot_scan", allpot, ap);
            chk("potval_scan", pot_val, pack_exp());
            t++;
            for (int n = 0; n < NP; n++) begin
                if (rise[n] == t) pot_in[n] = 1'b1;
                else if (!ap[n]) pot_in[n] = 1'($urandom_range(0, 1));
            end
            if (ap == '0) done = 1;
            if (stop_cnt >= 0 && cnt == stop_cnt) done = 1;
        end
    endtask

    task automatic finish_scan();
        repeat (3) cyc();
        chk("busy_idle", scan_busy, 0);
        chk("dump_idle", pot_dump, {NP{1'b1}});
        chk("allpot_idle", allpot, 0);
        chk("potval_idle", pot_val, pack_exp());
    endtask

    task automatic trig_step(input string tag);
        cyc();
        #1;
        chk(tag, trig_out, trig_latch_en ? m_latch : h1);
    endtask

    initial begin
        int lows;
        for (int n = 0; n < NP; n++) exp_val[n] = 8'd0;

        repeat (3) @(posedge o2);
        #1;
        rst_L = 1'b1;
        chk("rst_potval", pot_val, 0);
        chk("rst_allpot", allpot, 0);
        chk("rst_dump", pot_dump, {NP{1'b1}});
        chk("rst_busy", scan_busy, 0);
        chk("rst_trig", trig_out, {NT{1'b1}});
        repeat (10) cyc();
        chk("idle_dump", pot_dump, {NP{1'b1}});
        chk("idle_allpot", allpot, 0);
        chk("idle_potval", pot_val, 0);
        chk("idle_trig", trig_out, {NT{1'b1}});

        rise[0] = 40; rise[1] = 100;
        start_scan(0); scan_loop(-1); finish_scan();
        chk("pot0_is_40", pot_val[7:0], 40);

        rise[0] = 40; rise[1] = 9999;
        start_scan(0); scan_loop(-1); finish_scan();
        chk("pot1_full", pot_val[15:8], MAXC);

        rise[0] = 0; rise[1] = 0;
        start_scan(0); scan_loop(-1); finish_scan();

        rise[0] = 20; rise[1] = 9999;
        start_scan(0); scan_loop(50);
        rise[0] = 60; rise[1] = 5;
        start_scan(1); scan_loop(-1); finish_scan();

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < NP; n++) rise[n] = $urandom_range(0, 240);
            start_scan(0); scan_loop(-1); finish_scan();
        end

`ifdef POKEY_POT_FAST_SCAN_EN
        fast_scan = 1'b1;
        pot_in = '0;
        repeat (3) cyc();
        potgo_stb = 1'b1;
        cyc();
        potgo_stb = 1'b0;
        for (int d = 0; d < DT; d++) tick();
        fast_scan = 1'b0;
        repeat (8) cyc();
        pot_in[0] = 1'b1;
        repeat (300) cyc();
        exp_val[0] = 8'd10;
        exp_val[1] = 8'(MAXC);
        chk("fast_potval", pot_val, pack_exp());
        chk("fast_allpot", allpot, 0);
`endif

        trig_latch_en = 1'b1;
        repeat (3) trig_step("trig_latch_pre");
        trig_in[2] = 1'b0;
        repeat (3) trig_step("trig_latch_pulse");
        trig_in[2] = 1'b1;
        repeat (6) trig_step("trig_latch_hold");
        chk("trig2_latched", trig_out[2], 0);
        trig_latch_en = 1'b0;
        #1;
        chk("trig2_released", trig_out[2], 1);
        repeat (3) trig_step("trig_raw_pre");
        lows = 0;
        trig_in[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) trig_in[2] = 1'b1;
            trig_step("trig_raw_pulse");
            if (trig_out[2] == 1'b0) lows++;
        end
        chk("trig2_raw_width", lows, 3);

        for (int c = 0; c < 300; c++) begin
            trig_in = NT'($urandom);
            if ($urandom_range(0, 15) == 0) trig_latch_en = ~trig_latch_en;
            trig_step("trig_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
